// File: rtl/rcc_pkg.sv
// Shared constants and types for the RCC multi-channel clock divider.
// rcc_chan_state_t is the default-width view of one channel's divider state.
package rcc_pkg;

    localparam int RCC_MIN_RATIO = 2;
    localparam int RCC_DEF_NCH   = 4;
    localparam int RCC_DEF_WIDTH = 8;

    typedef struct packed {
        logic [RCC_DEF_WIDTH-1:0] cnt;
        logic [RCC_DEF_WIDTH-1:0] ratio;
        logic [RCC_DEF_WIDTH-1:0] pend_ratio;
        logic                     pend;
    } rcc_chan_state_t;

endpackage

// File: rtl/rcc_div_chan.sv
// One divider channel: counter, period-boundary ratio update, pending ratio
// register and registered OUT_CLK / TICK.
module rcc_div_chan
    import rcc_pkg::*;
#(
    parameter int WIDTH       = RCC_DEF_WIDTH,
    parameter int RESET_RATIO = 2
) (
    input  logic             REF_CLK,
    input  logic             RST,
    input  logic             SYNC,
    input  logic             WE,
    input  logic [WIDTH-1:0] WR_RATIO,
    output logic             PEND,
    output logic             OUT_CLK,
    output logic             TICK
);

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] ratio;
        logic [WIDTH-1:0] pend_ratio;
        logic             pend;
    } chan_state_t;

    localparam logic [WIDTH-1:0] RST_RATIO = WIDTH'(RESET_RATIO);
    localparam logic [WIDTH-1:0] RST_CNT   =
        (RESET_RATIO >= RCC_MIN_RATIO) ? WIDTH'(RESET_RATIO - 1) : '0;

    chan_state_t      st, st_nxt;
    logic             out_q, out_nxt;
    logic             tick_q, tick_nxt;
    logic             stopped, last, boundary, run;
    logic [WIDTH-1:0] new_ratio;
    logic [WIDTH:0]   cnt_inc, half;

    always_comb begin
        stopped   = st.ratio < WIDTH'(RCC_MIN_RATIO);
        last      = st.cnt == (st.ratio - WIDTH'(1));
        boundary  = SYNC | stopped | last;
        // Same-edge write beats the pending ratio, which beats the current one.
        new_ratio = WE ? WR_RATIO : (st.pend ? st.pend_ratio : st.ratio);
        run       = new_ratio >= WIDTH'(RCC_MIN_RATIO);
        cnt_inc   = {1'b0, st.cnt} + (WIDTH+1)'(1);
        half      = ({1'b0, st.ratio} + (WIDTH+1)'(1)) >> 1;

        st_nxt     = st;
        st_nxt.cnt = cnt_inc[WIDTH-1:0];
        out_nxt    = cnt_inc < half;
        tick_nxt   = 1'b0;

        if (boundary) begin
            st_nxt.ratio = new_ratio;
            st_nxt.pend  = 1'b0;
            st_nxt.cnt   = '0;
            out_nxt      = run;
            tick_nxt     = run;
        end else if (WE) begin
            st_nxt.pend_ratio = WR_RATIO;
            st_nxt.pend       = 1'b1;
        end
    end

    always_ff @(posedge REF_CLK or posedge RST) begin
        if (RST) begin
            st.cnt        <= RST_CNT;
            st.ratio      <= RST_RATIO;
            st.pend_ratio <= '0;
            st.pend       <= 1'b0;
            out_q         <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            st     <= st_nxt;
            out_q  <= out_nxt;
            tick_q <= tick_nxt;
        end
    end

    assign PEND    = st.pend;
    assign OUT_CLK = out_q;
    assign TICK    = tick_q;

endmodule

// File: rtl/rcc_clk_div_multi.sv
// Multi-channel glitch-free integer clock divider: decodes the config port
// into per-channel write strobes and fans SYNC out to every channel.
module rcc_clk_div_multi
    import rcc_pkg::*;
#(
    parameter int NCH         = RCC_DEF_NCH,
    parameter int WIDTH       = RCC_DEF_WIDTH,
    parameter int RESET_RATIO = 2,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             REF_CLK,
    input  logic             RST,
    input  logic             SYNC,
    input  logic             CFG_WE,
    input  logic [CH_W-1:0]  CFG_CH,
    input  logic [WIDTH-1:0] CFG_RATIO,
    output logic [NCH-1:0]   CFG_PEND,
    output logic [NCH-1:0]   OUT_CLK,
    output logic [NCH-1:0]   TICK
);

    logic [NCH-1:0] wr_en;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        // Channel numbers at or above NCH never match, so such writes drop.
        assign wr_en[i] = CFG_WE && (CFG_CH == CH_W'(i));

        rcc_div_chan #(
            .WIDTH       (WIDTH),
            .RESET_RATIO (RESET_RATIO)
        ) u_chan (
            .REF_CLK  (REF_CLK),
            .RST      (RST),
            .SYNC     (SYNC),
            .WE       (wr_en[i]),
            .WR_RATIO (CFG_RATIO),
            .PEND     (CFG_PEND[i]),
            .OUT_CLK  (OUT_CLK[i]),
            .TICK     (TICK[i])
        );
    end

endmodule

// File: doc/rcc_clk_div_multi.md
# rcc_clk_div_multi

Multi-channel, run-time reprogrammable integer clock divider for the RCC. It generates NCH independent divided clocks from REF_CLK, each with any ratio from 2 to 2^WIDTH-1, odd ratios included. Ratio changes are glitch-free because they take effect only at a period boundary. Every output is a flop output, and a per-channel TICK pulse is available as a clock-enable alternative.

## Interface
- NCH, 4: number of divider channels (≥1)
- WIDTH, 8: ratio width in bits (≥2)
- RESET_RATIO, 2: ratio loaded into every channel at reset (<2 means the channel resets stopped)
- REF_CLK  in  1  reference clock; the only clock
- RST  in  1  asynchronous, active-high reset
- SYNC  in  1  forces all channels to a period boundary on this edge
- CFG_WE  in  1  ratio write strobe, sampled at posedge REF_CLK
- CFG_CH  in  max(1,$clog2(NCH))  target channel; values ≥NCH are ignored
- CFG_RATIO  in  WIDTH  new ratio, unsigned
- CFG_PEND  out  NCH  channel holds a written ratio not yet applied
- OUT_CLK  out  NCH  divided clocks, registered
- TICK  out  NCH  one-cycle pulse during the first high cycle of each OUT_CLK period

## Operation
- Per-channel state:
  - active ratio N (WIDTH)
  - counter cnt (WIDTH)
  - pending ratio P plus pending flag
  - OUT_CLK and TICK flops
- Running channel (N≥2):
  - cnt counts 0..N-1 and wraps.
  - OUT_CLK is high for cnt in 0..H-1 and low for H..N-1, where H=(N+1)>>1, computed at WIDTH+1 bits.
  - Even N gives 50% duty; odd N gives one extra high cycle.
- Boundary: the edge where cnt==N-1, or any edge while the channel is stopped, or any edge with SYNC=1.
- At a boundary the new ratio M is chosen in this priority: write hitting this channel on the same edge, then P if pending, then N. Then:
  - N<=M, pending flag <=0.
  - If M≥2: cnt<=0, OUT_CLK<=1, TICK<=1.
  - If M<2: cnt<=0, OUT_CLK<=0, TICK<=0, and the channel becomes stopped.
- Write on a non-boundary edge: P<=CFG_RATIO and pending flag <=1. A later write overwrites P; the last write wins.
- Stopped channel: OUT_CLK is held at 0. A write with ratio ≥2 starts the channel on the same edge, because every edge of a stopped channel is a boundary.
- Ratios 0 and 1 both mean stop. There is no REF_CLK bypass path, so no combinational clock muxing exists.
- SYNC takes priority over normal counting. It re-aligns every running channel to cnt=0 with OUT_CLK high on the same edge.
- CFG_PEND[i] is the pending flag of channel i.

## Timing
- Reset values for every channel:
  - OUT_CLK=0, TICK=0, CFG_PEND=0
  - N=RESET_RATIO
  - cnt=RESET_RATIO-1 if RESET_RATIO≥2, otherwise 0
- The first posedge after RST falls is a boundary: with RESET_RATIO≥2, OUT_CLK rises on that edge.
- Write latency:
  - A write on boundary edge E applies at E.
  - A write otherwise applies at the next boundary, at most N-1 edges later, and CFG_PEND is high in between.
- TICK: high exactly one REF_CLK cycle, coincident with the first high cycle of OUT_CLK.
- RST mid-period: all outputs return to their reset values asynchronously, and pending writes are discarded.
- OUT_CLK changes only on posedge REF_CLK. There are no runt pulses: the minimum high or low phase is 1 REF_CLK period, at N=2 or N=3.

## Structure
- Package rcc_pkg holds:
  - RCC_MIN_RATIO = 2
  - default widths
  - a typedef for the per-channel state struct (cnt, ratio, pend_ratio, pend)
- Sub-module rcc_div_chan implements one channel: counter, boundary logic, pending register and output flops.
- Top rcc_clk_div_multi contains:
  - CFG_CH decode into per-channel write-enables
  - SYNC fan-out
  - a generate loop of NCH rcc_div_chan instances

## Test plan
- Reset with RESET_RATIO=2, release RST -> every OUT_CLK rises on the first edge and toggles every edge; TICK is high every other cycle.
- Write ratio 3 to ch0 -> OUT_CLK[0] pattern repeats 1,1,0, and TICK[0] is high once per 3 cycles.
- Ratio 8 running on ch1; write 5 at cnt=2, then 6 at cnt=4 -> CFG_PEND[1] is high until the cnt=7 edge, after which the period is 6 (3 high, 3 low); ratio 5 never appears.
- Write 0 to ch2 -> at the next boundary OUT_CLK[2] is held 0; writing 4 starts it with OUT_CLK high on the write edge.
- Ch0=4 and ch1=6 at arbitrary phases; pulse SYNC -> both outputs go high on the same edge and follow 4- and 6-cycle periods from cnt=0.
- Assert RST at mid-period with a pending write, then release -> outputs are 0 during reset, CFG_PEND=0, and the RESET_RATIO behaviour resumes.
